// File: rtl/video_mem_arb_pkg.sv
// rtl/video_mem_arb_pkg.sv - shared types and constants for the video memory arbiter
package video_mem_arb_pkg;
  localparam int         ADDR_W         = 23;
  localparam logic [1:0] VIDEO_SLOT_DEF = 2'd0;
  localparam int         STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETURN = 2'd2
  } arb_state_e;
endpackage

// File: rtl/video_mem_arb_slot_detect.sv
// rtl/video_mem_arb_slot_detect.sv - bus_cycle edge register producing slot start/end pulses
module slot_detect
  import video_mem_arb_pkg::*;
#(
  parameter logic [1:0] VIDEO_SLOT = VIDEO_SLOT_DEF
) (
  input  logic       clk_32,
  input  logic       reset,
  input  logic [1:0] bus_cycle,
  output logic       slot_start,
  output logic       slot_end
);
  logic [1:0] prev_cycle;

  // Reset value of VIDEO_SLOT keeps a slot already in progress at release from being taken.
  always_ff @(posedge clk_32) begin
    if (reset) prev_cycle <= VIDEO_SLOT;
    else       prev_cycle <= bus_cycle;
  end

  assign slot_start = (bus_cycle == VIDEO_SLOT) && (prev_cycle != VIDEO_SLOT);
  assign slot_end   = (bus_cycle != VIDEO_SLOT) && (prev_cycle == VIDEO_SLOT);
endmodule

// File: rtl/video_mem_arb.sv
// rtl/video_mem_arb.sv - two-requester video read-slot arbiter with starvation guard
module video_mem_arb
  import video_mem_arb_pkg::*;
#(
  parameter logic [1:0] VIDEO_SLOT = VIDEO_SLOT_DEF,
  parameter int         STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_32,
  input  logic              reset,
  input  logic [1:0]        bus_cycle,
  input  logic              viking_enable,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [ADDR_W-1:0] vaddr,
  output logic              read,
  input  logic [63:0]       data,
  output logic [63:0]       data_out
);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_e state;
  logic       slot_start;
  logic       slot_end;
  logic       winner;
  logic [2:0] starve_cnt;
  logic       elig0;
  logic       elig1;
  logic       grant1;

  slot_detect #(.VIDEO_SLOT(VIDEO_SLOT)) u_slot_detect (
    .clk_32     (clk_32),
    .reset      (reset),
    .bus_cycle  (bus_cycle),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  // Viking mode masks requester 0 entirely; otherwise requester 0 wins unless 1 is starved.
  always_comb begin
    elig0  = req0 && !viking_enable;
    elig1  = req1;
    grant1 = elig1 && (!elig0 || (starve_cnt == STARVE_LIM));
  end

  always_ff @(posedge clk_32) begin
    if (reset) begin
      state      <= IDLE;
      read       <= 1'b0;
      vaddr      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      data_out   <= '0;
      starve_cnt <= '0;
      winner     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_start) begin
            if (viking_enable || !req1 || grant1) starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)     starve_cnt <= starve_cnt + 3'd1;
            if (elig0 || elig1) begin
              winner <= grant1;
              read   <= 1'b1;
              vaddr  <= grant1 ? addr1 : addr0;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // The read runs to completion even if the winner drops its request.
          if (slot_end) begin
            data_out <= data;
            read     <= 1'b0;
            ack0     <= !winner;
            ack1     <= winner;
            state    <= RETURN;
          end
        end
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
